// File: rtl/avalon_mm_read_master.sv
// Avalon-MM block read master feeding a valid/ready stream; first avm_read one cycle after start, 1 word/cycle sustained.
// Backpressure: issue is credit-limited so buffered plus in-flight reads never exceed FIFO_DEPTH.

module avm_rd_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_vld,
    input  logic [W-1:0]           wr_dat,
    input  logic                   rd_rdy,
    output logic                   rd_vld,
    output logic [W-1:0]           rd_dat,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          pop;

    assign rd_vld = (count != '0);
    assign rd_dat = mem[rd_ptr];
    assign pop    = rd_vld && rd_rdy;

    // A write into the slot being popped on a full FIFO is safe: the head is read before the edge.
    always_ff @(posedge clk) begin
        if (wr_vld) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_vld) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + (AW+1)'(wr_vld) - (AW+1)'(pop);
        end
    end

    no_overflow: assert property (@(posedge clk) disable iff (reset)
        (wr_vld && !pop) |-> (count != (AW+1)'(DEPTH)));

endmodule

module avalon_mm_read_master #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LEN_W      = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [LEN_W-1:0]      length,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_W-1:0]     avm_address,
    output logic                  avm_read,
    output logic [DATA_W/8-1:0]   avm_byteenable,
    input  logic                  avm_waitrequest,
    input  logic [DATA_W-1:0]     avm_readdata,
    input  logic                  avm_readdatavalid,
    output logic [DATA_W-1:0]     st_data,
    output logic                  st_valid,
    input  logic                  st_ready
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(DATA_W / 8);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  issue_left;
    logic [LEN_W-1:0]  recv_left;
    logic [CW-1:0]     outstanding;
    logic [CW-1:0]     fifo_count;

    logic              accept;
    logic              rx;
    logic              pop;
    logic [LEN_W-1:0]  issue_left_nxt;
    logic [LEN_W-1:0]  recv_left_nxt;
    logic [CW-1:0]     outstanding_nxt;
    logic [CW-1:0]     fifo_count_nxt;
    logic [CW:0]       in_use_nxt;
    logic              issue_more;

    assign accept = avm_read && !avm_waitrequest;
    assign rx     = avm_readdatavalid && (state == RUN) && (recv_left != '0);
    assign pop    = st_valid && st_ready;

    // Look one cycle ahead so the registered avm_read never claims a slot that is not free.
    assign issue_left_nxt  = issue_left - LEN_W'(accept);
    assign recv_left_nxt   = recv_left - LEN_W'(rx);
    assign outstanding_nxt = outstanding + CW'(accept) - CW'(rx);
    assign fifo_count_nxt  = fifo_count + CW'(rx) - CW'(pop);
    assign in_use_nxt      = {1'b0, outstanding_nxt} + {1'b0, fifo_count_nxt};
    assign issue_more      = (issue_left_nxt != '0) && (in_use_nxt < (CW+1)'(FIFO_DEPTH));

    assign avm_address    = addr;
    assign avm_byteenable = '1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            addr        <= '0;
            issue_left  <= '0;
            recv_left   <= '0;
            outstanding <= '0;
            avm_read    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    outstanding <= '0;
                    if (start) begin
                        if (length == '0) begin
                            done <= 1'b1;
                        end else begin
                            addr       <= base_addr;
                            issue_left <= length;
                            recv_left  <= length;
                            busy       <= 1'b1;
                            avm_read   <= 1'b1;
                            state      <= RUN;
                        end
                    end
                end
                RUN: begin
                    issue_left  <= issue_left_nxt;
                    recv_left   <= recv_left_nxt;
                    outstanding <= outstanding_nxt;
                    if (accept) begin
                        addr <= addr + STRIDE;
                    end
                    if (avm_read && avm_waitrequest) begin
                        avm_read <= 1'b1;
                    end else begin
                        avm_read <= issue_more;
                    end
                    if (recv_left_nxt == '0) begin
                        avm_read <= 1'b0;
                        state    <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (fifo_count_nxt == '0) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    avm_rd_fifo #(
        .W     (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .wr_vld (rx),
        .wr_dat (avm_readdata),
        .rd_rdy (st_ready),
        .rd_vld (st_valid),
        .rd_dat (st_data),
        .count  (fifo_count)
    );

endmodule

// File: tb/tb_avalon_mm_read_master.sv
// Directed bench for avalon_mm_read_master: scripted slave, expected-address and expected-data scoreboards.
module tb_avalon_mm_read_master;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] base_addr;
    logic [15:0] length;
    logic        busy;
    logic        done;
    logic [31:0] avm_address;
    logic        avm_read;
    logic [3:0]  avm_byteenable;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        avm_readdatavalid;
    logic [31:0] st_data;
    logic        st_valid;
    logic        st_ready;

    avalon_mm_read_master #(
        .ADDR_W(32), .DATA_W(32), .LEN_W(16), .FIFO_DEPTH(8)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .base_addr         (base_addr),
        .length            (length),
        .busy              (busy),
        .done              (done),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_byteenable    (avm_byteenable),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid),
        .st_data           (st_data),
        .st_valid          (st_valid),
        .st_ready          (st_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [31:0] addr;
    } pend_t;

    int          tests = 0;
    int          failed = 0;
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    pend_t       pend_q[$];
    int          acc_cnt = 0;
    int          done_cnt = 0;
    int          cyc = 0;
    int          lat = 1;
    int          stall_idx = -1;
    int          stall_rem = 0;
    bit          busy_seen = 0;
    bit          rd_seen = 0;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return 32'h11 * ((a >> 2) + 32'd1);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Slave: decides waitrequest, scoreboards accepted addresses, returns data after lat cycles.
    initial begin
        avm_waitrequest   = 1'b0;
        avm_readdatavalid = 1'b0;
        avm_readdata      = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
                pend_t p;
                p = pend_q.pop_front();
                avm_readdatavalid = 1'b1;
                avm_readdata      = word_at(p.addr);
            end else begin
                avm_readdatavalid = 1'b0;
                avm_readdata      = '0;
            end
            if (acc_cnt == stall_idx && stall_rem > 0) begin
                avm_waitrequest = 1'b1;
                stall_rem--;
                check("stall_read", 64'(avm_read), 64'(1));
                check("stall_addr", 64'(avm_address), 64'(32'h4));
            end else begin
                avm_waitrequest = 1'b0;
            end
            if (avm_read && !avm_waitrequest) begin
                acc_cnt++;
                if (exp_addr_q.size() == 0) begin
                    tests++;
                    failed++;
                    $display("FAIL rd_unexpected: got read at %0h, required no read", avm_address);
                end else begin
                    check("rd_addr", 64'(avm_address), 64'(exp_addr_q.pop_front()));
                end
                pend_q.push_back('{cyc + lat, avm_address});
            end
        end
    end

    // Stream monitor.
    initial begin
        forever begin
            @(negedge clk);
            if (done) done_cnt++;
            if (busy) busy_seen = 1'b1;
            if (avm_read) rd_seen = 1'b1;
            if (st_valid && st_ready) begin
                if (exp_data_q.size() == 0) begin
                    tests++;
                    failed++;
                    $display("FAIL st_unexpected: got %0h, required no word", st_data);
                end else begin
                    check("st_data", 64'(st_data), 64'(exp_data_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish in time");
        $fatal(1, "watchdog");
    end

    task automatic start_xfer(input logic [31:0] base, input int len, input bit push_data);
        for (int i = 0; i < len; i++) begin
            exp_addr_q.push_back(base + 32'(4 * i));
            if (push_data) exp_data_q.push_back(word_at(base + 32'(4 * i)));
        end
        acc_cnt   = 0;
        done_cnt  = 0;
        base_addr = base;
        length    = 16'(len);
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done(input string name, input int bound);
        bit got;
        got = 1'b0;
        for (int i = 0; i < bound; i++) begin
            tick();
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        check({name, "_done"}, 64'(got), 64'(1));
        if (got) check({name, "_busy_at_done"}, 64'(busy), 64'(0));
        tick();
        check({name, "_done_once"}, 64'(done_cnt), 64'(1));
        check({name, "_addr_left"}, 64'(exp_addr_q.size()), 64'(0));
        check({name, "_data_left"}, 64'(exp_data_q.size()), 64'(0));
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        length    = '0;
        st_ready  = 1'b1;
        repeat (3) tick();
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_read", 64'(avm_read), 64'(0));
        check("rst_st_valid", 64'(st_valid), 64'(0));
        check("rst_addr", 64'(avm_address), 64'(0));
        check("byteenable", 64'(avm_byteenable), 64'(4'hF));
        reset = 1'b0;
        tick();

        // Basic transfer with literal data values.
        exp_data_q.push_back(32'h11);
        exp_data_q.push_back(32'h22);
        exp_data_q.push_back(32'h33);
        exp_data_q.push_back(32'h44);
        start_xfer(32'h0, 4, 1'b0);
        check("basic_busy", 64'(busy), 64'(1));
        check("basic_read0", 64'(avm_read), 64'(1));
        check("basic_addr0", 64'(avm_address), 64'(32'h0));
        tick();
        check("basic_addr1", 64'(avm_address), 64'(32'h4));
        tick();
        check("basic_addr2", 64'(avm_address), 64'(32'h8));
        tick();
        check("basic_addr3", 64'(avm_address), 64'(32'hC));
        wait_done("basic", 50);
        check("basic_reads", 64'(acc_cnt), 64'(4));

        // Zero length.
        busy_seen = 1'b0;
        rd_seen   = 1'b0;
        start_xfer(32'h40, 0, 1'b1);
        check("zero_done", 64'(done), 64'(1));
        check("zero_busy", 64'(busy), 64'(0));
        tick();
        check("zero_done_pulse", 64'(done), 64'(0));
        repeat (4) tick();
        check("zero_busy_never", 64'(busy_seen), 64'(0));
        check("zero_read_never", 64'(rd_seen), 64'(0));

        // Slave stall on the second read.
        stall_idx = 1;
        stall_rem = 5;
        start_xfer(32'h0, 4, 1'b1);
        wait_done("stall", 60);
        check("stall_cycles_used", 64'(stall_rem), 64'(0));
        stall_idx = -1;

        // Address wrap at 2^32.
        start_xfer(32'hFFFF_FFF8, 4, 1'b1);
        wait_done("wrap", 50);

        // Downstream backpressure, with a start pulse while busy.
        st_ready = 1'b0;
        start_xfer(32'h1000, 20, 1'b1);
        for (int i = 0; i < 30; i++) begin
            if (i == 5) begin
                base_addr = 32'h200;
                length    = 16'd5;
                start     = 1'b1;
            end
            tick();
            start = 1'b0;
        end
        check("bp_reads_capped", 64'(acc_cnt), 64'(8));
        check("bp_read_low", 64'(avm_read), 64'(0));
        check("bp_busy", 64'(busy), 64'(1));
        check("bp_head_valid", 64'(st_valid), 64'(1));
        check("bp_head_data", 64'(st_data), 64'(word_at(32'h1000)));
        st_ready = 1'b1;
        wait_done("bp", 300);
        check("bp_reads_total", 64'(acc_cnt), 64'(20));

        // Reset mid-transfer with slow responses still in flight.
        lat = 3;
        start_xfer(32'h0, 8, 1'b0);
        for (int i = 0; i < 50 && acc_cnt < 3; i++) tick();
        check("abort_reads_seen", 64'(acc_cnt >= 3), 64'(1));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_done", 64'(done), 64'(0));
        check("abort_read", 64'(avm_read), 64'(0));
        check("abort_st_valid", 64'(st_valid), 64'(0));
        check("abort_addr", 64'(avm_address), 64'(0));
        exp_addr_q.delete();
        repeat (6) tick();
        check("abort_stale_dropped", 64'(st_valid), 64'(0));
        lat = 1;
        start_xfer(32'h100, 2, 1'b1);
        wait_done("after_rst", 50);
        check("after_rst_reads", 64'(acc_cnt), 64'(2));

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/avalon_mm_read_master.md
Name: avalon_mm_read_master

Overview:
- Avalon-MM master that reads a block of consecutive words from any Avalon-MM memory slave (e.g. the on-chip RAM) and presents them as a valid/ready stream.
- Sits between the SoC fabric and pixel/sprite consumers in the Pokemon_soc fabric.
- Supports pipelined reads with readdatavalid.
- Uses credit-based issue so an internal FIFO can never overflow under downstream backpressure.

Parameters:
- ADDR_W, 32, byte-address width of avm_address and base_addr.
- DATA_W, 32, data width; a multiple of 8. Word stride = DATA_W/8 bytes.
- LEN_W, 16, width of the word-count input.
- FIFO_DEPTH, 8, response FIFO entries; a power of 2, >= 2. Also the maximum number of outstanding reads.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  1-cycle request to begin a transfer; sampled only in IDLE.
- base_addr  in  ADDR_W  first byte address; captured on accepted start.
- length  in  LEN_W  number of words to read; captured on accepted start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  1-cycle pulse when the transfer completes.
- avm_address  out  ADDR_W  read byte address.
- avm_read  out  1  read request.
- avm_byteenable  out  DATA_W/8  held all-ones.
- avm_waitrequest  in  1  slave stall.
- avm_readdata  in  DATA_W  read data.
- avm_readdatavalid  in  1  readdata qualifier.
- st_data  out  DATA_W  stream word, FIFO head.
- st_valid  out  1  stream valid.
- st_ready  in  1  stream ready from the consumer.

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE; FIFO is emptied; counters are cleared.
  - busy, done, avm_read, st_valid are 0; avm_address is 0.
  - Reset mid-transfer aborts immediately; late readdatavalid beats after reset are discarded.
- States:
  - IDLE:
    - start=1 with length=0: done pulses the next cycle; busy stays 0; no reads are issued.
    - start=1 with length>0: capture addr=base_addr, issue_left=length, recv_left=length; go to RUN. busy=1 from the next cycle.
  - RUN: issue and receive reads.
    - Go to DRAIN when recv_left reaches 0.
  - DRAIN: wait for the FIFO to empty, then return to IDLE.
    - done pulses in the same cycle busy falls.
- start while busy is ignored.
- Issue rule:
  - avm_read=1 when issue_left>0 and credits>0.
  - credits = FIFO_DEPTH − (outstanding + fifo_count).
  - A read is accepted on a cycle with avm_read=1 and avm_waitrequest=0. On acceptance:
    - addr += DATA_W/8;
    - issue_left −= 1;
    - outstanding += 1.
  - While waitrequest=1, avm_read and avm_address are held stable.
  - avm_read is registered. The credit calculation must account for the accept and the FIFO pop of the current cycle, so that no more than FIFO_DEPTH reads are ever in flight plus buffered.
- Receive rule:
  - Each avm_readdatavalid=1 in RUN pushes avm_readdata, decrements outstanding and decrements recv_left.
  - readdatavalid in IDLE or DRAIN is ignored.
- Stream:
  - st_valid = FIFO not empty; st_data = FIFO head.
  - Pop when st_valid and st_ready.
  - A push and a pop in the same cycle, including when the FIFO is full, keep the count unchanged and preserve ordering.
- Address wrap-around at 2^ADDR_W is modulo; no error.
- Throughput: 1 word/cycle sustained with a zero-wait slave and st_ready=1.
- Latency: first avm_read is asserted the cycle after the accepted start.

Test Plan:
- Basic transfer:
  - Stimulus: base_addr=0x0, length=4, zero-wait slave with 1-cycle readdatavalid returning 0x11,0x22,0x33,0x44; st_ready=1.
  - Response: addresses 0x0,0x4,0x8,0xC on consecutive cycles; stream 0x11..0x44 in order; exactly one done pulse; busy then 0.
- Zero length:
  - Stimulus: length=0.
  - Response: no avm_read ever; done pulses one cycle after start; busy never 1.
- Slave stall:
  - Stimulus: avm_waitrequest=1 for 5 cycles on the 2nd read.
  - Response: avm_address holds 0x4 with avm_read=1 throughout the stall; no word is skipped or duplicated.
- Downstream backpressure:
  - Stimulus: length=20, st_ready=0.
  - Response: at most 8 reads are accepted, then avm_read=0; after st_ready=1, all 20 words arrive in order; no overflow.
- Reset and ignored start:
  - Stimulus: reset mid-transfer after 3 reads, then start base_addr=0x100, length=2.
  - Response: outputs are 0 the cycle after reset; stale readdatavalid is dropped; the new transfer reads 0x100, 0x104 only.
  - Stimulus: start pulsed while busy.
  - Response: ignored; the current transfer is unaffected.
